// File: rtl/ua_receive.sv
// ua_receive: UART byte receiver with 2-flop input synchronizer and valid/ready output.
// Define UA_RECEIVE_FRAMING_CHECK_EN to discard low-stop-bit frames and pulse FramingError.
module ua_receive #(
    parameter int ClockFreq = 100_000_000,
    parameter int BaudRate  = 115_200
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       SIn,
    output logic [7:0] DataOut,
    output logic       DataOutValid,
    input  logic       DataOutReady,
    output logic       FramingError
);
    localparam int SymbolEdgeTime = ClockFreq / BaudRate;
    localparam int SampleTime = SymbolEdgeTime / 2;
    localparam int CW = SymbolEdgeTime > 1 ? $clog2(SymbolEdgeTime) : 1;
    localparam logic [CW-1:0] EdgeLast = CW'(SymbolEdgeTime - 1);
    localparam logic [CW-1:0] SampleLast = CW'(SampleTime - 1);
    localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;

    logic [1:0] state;
    logic [CW-1:0] cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic sync1, sin_sync;
    logic edge_hit, stop_hit, stop_good, load;

    always_comb begin
        edge_hit = cnt == EdgeLast;
        stop_hit = state == STOP && edge_hit;
`ifdef UA_RECEIVE_FRAMING_CHECK_EN
        stop_good = sin_sync;
`else
        stop_good = 1'b1;
`endif
        load = stop_hit && stop_good && (!DataOutValid || DataOutReady);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            sync1 <= 1'b1;
            sin_sync <= 1'b1;
            state <= IDLE;
            cnt <= '0;
            bit_cnt <= '0;
            shreg <= '0;
            DataOut <= '0;
            DataOutValid <= 1'b0;
        end else begin
            sync1 <= SIn;
            sin_sync <= sync1;
            if (load) begin
                DataOut <= shreg;
                DataOutValid <= 1'b1;
            end else if (DataOutValid && DataOutReady) begin
                DataOutValid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!sin_sync) state <= START;
                end
                START: begin
                    if (cnt == SampleLast) begin
                        cnt <= '0;
                        state <= sin_sync ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (edge_hit) begin
                        cnt <= '0;
                        shreg <= {sin_sync, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (edge_hit) begin
                        cnt <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef UA_RECEIVE_FRAMING_CHECK_EN
    always_ff @(posedge Clock) begin
        if (Reset) FramingError <= 1'b0;
        else FramingError <= stop_hit && !sin_sync;
    end
`else
    assign FramingError = 1'b0;
`endif
endmodule
